filtro_window_ctrl: RTL

//  Sequencer for the 8-tap middle interpolation filter (filtromiddle). Accepts one row of samples as a

---
 rtl/filtro_pkg.sv | 18 +
 rtl/filtro_window_ctrl_if.sv | 21 ++
 rtl/filtro_out_fifo.sv | 56 +++++
 rtl/filtro_window_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// rtl/filtro_pkg.sv - shared states, tap counts and width helpers for the middle-filter sequencer
package filtro_pkg;

   typedef enum logic [2:0] {IDLE, FIRST, PRIME, RUN, FLUSH, DRAIN} state_e;

   localparam int NUM_TAPS = 8;
   localparam int PRE_PAD  = 3;
   localparam int POST_PAD = 4;

   function automatic int sample_w(input int dw);
      return dw + 2;
   endfunction

   function automatic int result_w(input int dw);
      return dw + 3;
   endfunction

endpackage

// File: rtl/filtro_window_ctrl_if.sv
// rtl/filtro_window_ctrl_if.sv - sample input stream and result output stream of the window sequencer
interface filtro_window_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH+1:0] in_sample;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [DATA_WIDTH+2:0] out_data;

   modport master (
      output in_valid, in_sample, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_sample, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/filtro_out_fifo.sv
// rtl/filtro_out_fifo.sv - synchronous result FIFO with same-cycle push and pop
module filtro_out_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q];

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_d = bump(wr_q);
      if (do_pop)  rd_d = bump(rd_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end
endmodule

// File: rtl/filtro_window_ctrl.sv
// rtl/filtro_window_ctrl.sv - sliding 8-tap window with edge replication, credit-gated issue to the
// middle filter and backpressured return of its results
module filtro_window_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ROW_WIDTH      = 64,
   parameter int FILTER_LATENCY = 1,
   parameter int OUT_DEPTH      = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   filtro_window_ctrl_if.slave          s_if,
   output logic signed [DATA_WIDTH+1:0] tap0,
   output logic signed [DATA_WIDTH+1:0] tap1,
   output logic signed [DATA_WIDTH+1:0] tap2,
   output logic signed [DATA_WIDTH+1:0] tap3,
   output logic signed [DATA_WIDTH+1:0] tap4,
   output logic signed [DATA_WIDTH+1:0] tap5,
   output logic signed [DATA_WIDTH+1:0] tap6,
   output logic signed [DATA_WIDTH+1:0] tap7,
   output logic                         filt_en,
   input  logic signed [DATA_WIDTH+2:0] filt_out,
   output logic                         row_done,
   output logic                         busy
);
   import filtro_pkg::*;

   localparam int SW = sample_w(DATA_WIDTH);
   localparam int RW = result_w(DATA_WIDTH);
   localparam int CW = $clog2(ROW_WIDTH + 1);
   localparam int KW = $clog2(OUT_DEPTH + 1);
   localparam int FW = $clog2(POST_PAD);

   state_e                      state_q, state_d;
   logic [NUM_TAPS-1:0][SW-1:0] win_q, win_d;
   logic [CW-1:0]               scnt_q, scnt_d, ocnt_q, ocnt_d;
   logic [FW-1:0]               fcnt_q, fcnt_d;
   logic [KW-1:0]               credits_q, credits_d;
   logic [FILTER_LATENCY:0]     tok_q;
   logic                        issue, in_rdy, out_hs, has_credit;
   logic                        fifo_push, fifo_empty, fifo_full;

   assign has_credit = (credits_q != '0);
   assign out_hs     = s_if.out_valid && s_if.out_ready;
   assign busy       = (state_q != IDLE);
   assign filt_en    = busy;
   assign s_if.in_ready = in_rdy;

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      scnt_d   = scnt_q;
      ocnt_d   = out_hs ? ocnt_q + CW'(1) : ocnt_q;
      fcnt_d   = fcnt_q;
      in_rdy   = 1'b0;
      issue    = 1'b0;
      row_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FIRST;
               scnt_d  = '0;
               ocnt_d  = '0;
               fcnt_d  = '0;
            end
         end
         FIRST: begin
            in_rdy = 1'b1;
            if (s_if.in_valid) begin
               win_d   = {NUM_TAPS{s_if.in_sample}};
               scnt_d  = CW'(1);
               state_d = PRIME;
            end
         end
         PRIME: begin
            // credits are always full here, so the first issue needs no gating
            in_rdy = 1'b1;
            if (s_if.in_valid) begin
               win_d  = {s_if.in_sample, win_q[NUM_TAPS-1:1]};
               scnt_d = scnt_q + CW'(1);
               if (scnt_q == CW'(PRE_PAD + 1)) begin
                  issue   = 1'b1;
                  state_d = (scnt_q == CW'(ROW_WIDTH - 1)) ? FLUSH : RUN;
               end
            end
         end
         RUN: begin
            in_rdy = has_credit;
            if (s_if.in_valid && has_credit) begin
               win_d  = {s_if.in_sample, win_q[NUM_TAPS-1:1]};
               scnt_d = scnt_q + CW'(1);
               issue  = 1'b1;
               if (scnt_q == CW'(ROW_WIDTH - 1)) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (has_credit) begin
               win_d  = {win_q[NUM_TAPS-1], win_q[NUM_TAPS-1:1]};
               fcnt_d = fcnt_q + FW'(1);
               issue  = 1'b1;
               if (fcnt_q == FW'(POST_PAD - 1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_hs && ocnt_q == CW'(ROW_WIDTH - 1)) begin
               row_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      credits_d = credits_q + KW'(out_hs) - KW'(issue);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         win_q     <= '0;
         scnt_q    <= '0;
         ocnt_q    <= '0;
         fcnt_q    <= '0;
         credits_q <= KW'(OUT_DEPTH);
         tok_q     <= '0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         scnt_q    <= scnt_d;
         ocnt_q    <= ocnt_d;
         fcnt_q    <= fcnt_d;
         credits_q <= credits_d;
         // stage 0 is the cycle the issued window sits on the taps; the last stage meets filt_out
         tok_q     <= {tok_q[FILTER_LATENCY-1:0], issue};
      end
   end

   assign tap0 = win_q[0];
   assign tap1 = win_q[1];
   assign tap2 = win_q[2];
   assign tap3 = win_q[3];
   assign tap4 = win_q[4];
   assign tap5 = win_q[5];
   assign tap6 = win_q[6];
   assign tap7 = win_q[7];

   assign fifo_push      = tok_q[FILTER_LATENCY] && !fifo_full;
   assign s_if.out_valid = !fifo_empty;

   filtro_out_fifo #(
      .DEPTH (OUT_DEPTH),
      .WIDTH (RW)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (fifo_push),
      .din_i   (filt_out),
      .pop_i   (out_hs),
      .dout_o  (s_if.out_data),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );
endmodule
